cpu_regfile: RTL and testbench
==============================

# cpu_regfile

Parametrised architectural register file for the 6502 core: A, X, Y, stack pointer, status (P) and program counter, with reset, stall, PC increment/load, stack push/pull counting and per-flag status updates. Sits between the decode/control FSM and the ALU. Replaces the fixed 8-bit write-only register bank. All state is registered, and outputs reflect updates one cycle after the controlling inputs.

## Interface
Parameters:
- `DATA_W`, 8: width of A, X, Y, SP and P.
- `ADDR_W`, 16: width of the PC.
- `PC_RESET`, 16'hFFFC: PC value after reset.
- `SP_RESET`, 8'hFD: SP value after reset.
- `SP_PAGE`, 8'h01: high byte of the stack address.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: freezes every register; all ops ignored.
- `wr_en` in 1: writes `wr_data` to the register selected by `wr_dest`.
- `wr_dest` in 3: `reg_sel_t` (A, X, Y, SP, P).
- `wr_data` in DATA_W: write data (ALU hold register).
- `auto_nz` in 1: on A/X/Y writes, also update N and Z from `wr_data`.
- `flag_we` in DATA_W: per-bit status write mask.
- `flag_in` in DATA_W: per-bit status values.
- `pc_op` in 2: `pc_op_t` (HOLD, INC, LOAD).
- `pc_load` in ADDR_W: PC load value.
- `sp_op` in 2: `sp_op_t` (HOLD, PUSH, PULL).
- `acc_reg`, `x_reg`, `y_reg`, `sp_reg`, `status_reg` out DATA_W: register values.
- `pc` out ADDR_W: program counter.
- `push_addr` out ADDR_W: {SP_PAGE, sp_reg}.
- `pull_addr` out ADDR_W: {SP_PAGE, sp_reg+1}, with the low byte wrapping.

## Operation
- Reset (`rst_n`=0, async): A=X=Y=0, SP=SP_RESET, PC=PC_RESET, P=8'h24 (I=1, bit5=1). All other bits are 0.
- `stall`=1: no register changes regardless of other inputs. Reset still overrides `stall`.
- A/X/Y write: the selected register takes `wr_data`. If `auto_nz`: N=`wr_data`[DATA_W-1], Z=(`wr_data`==0).
- SP write (`wr_dest`=SP, e.g. TXS): SP takes `wr_data`, and `sp_op` is ignored that cycle.
- P write (`wr_dest`=P, e.g. PLP): P takes `wr_data`, with bit5 forced 1 and bit4 (B) forced 0.
- Flag update: for each bit i where `flag_we`[i]=1, P[i]=`flag_in`[i].
- Precedence on P, lowest to highest: hold, then full P write, then `auto_nz`, then `flag_we`. Bit5=1 and bit4=0 always, regardless of masks.
- SP ops: PUSH gives SP−1 and PULL gives SP+1, both modulo 2^DATA_W (00→FF on push, FF→00 on pull).
- PC ops: INC gives PC+1 modulo 2^ADDR_W (FFFF→0000). LOAD gives `pc_load`. HOLD leaves PC unchanged. The encoding value 2'b11 behaves as HOLD.
- Illegal `wr_dest` encodings: no register written.
- PC, SP and data writes are independent. Any combination is allowed in one cycle, subject to the SP rule above.

## Timing
- Single clock domain. All outputs come directly from flops except `push_addr`/`pull_addr`, which are combinational from `sp_reg`.
- Write latency 1: inputs sampled at edge N appear on outputs after edge N. No read-during-write bypass.
- Reset assertion takes effect immediately, independent of `clk`. Deassertion is synchronised upstream. The first update happens on the first edge after deassertion.
- Reset mid-operation discards any in-flight op, leaving no partial update.

## Structure
- `types` package: `reg_sel_t` (A=0, X=1, Y=2, SP=3, P=4), `pc_op_t`, `sp_op_t`, and flag bit indices `FLAG_C`=0, `FLAG_Z`=1, `FLAG_I`=2, `FLAG_D`=3, `FLAG_B`=4, `FLAG_V`=6, `FLAG_N`=7.
- Sub-module `status_flags`: holds P and implements the precedence and bit5/bit4 forcing. The top module holds A/X/Y/SP/PC.

## Test plan
- Reset: pulse `rst_n` low mid-cycle → immediately A=X=Y=0, SP=FD, PC=FFFC, P=24.
- Write with N/Z: write A=80 with `auto_nz` → next cycle A=80, N=1, Z=0. Then X=00 → X=00, Z=1, N=0, A unchanged.
- Stack wrap: SP=01, then PUSH ×3 → 00, FF, FE; `push_addr`=01FE, `pull_addr`=01FF. Also SP write=FF together with PULL → SP=FF (write wins).
- PC: PC=FFFE, INC ×2 → FFFF then 0000. LOAD 1234 with `stall`=1 → PC unchanged; with `stall` released → 1234.
- P precedence: P write=FF with `flag_we`=01, `flag_in`=00 → P=EE (C cleared, B=0, bit5=1).
- Flag masking: `flag_we`=C0, `flag_in`=40 with `auto_nz` write A=00 → N=0, V=1, Z=1, other flags held.

Source files
------------

// File: rtl/cpu_regfile_pkg.sv
// cpu_regfile_pkg: register select, PC/SP op encodings and status flag bit positions.
package cpu_regfile_pkg;

    typedef enum logic [2:0] {
        REG_A  = 3'd0,
        REG_X  = 3'd1,
        REG_Y  = 3'd2,
        REG_SP = 3'd3,
        REG_P  = 3'd4
    } reg_sel_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_op_t;

    typedef enum logic [1:0] {
        SP_HOLD = 2'd0,
        SP_PUSH = 2'd1,
        SP_PULL = 2'd2
    } sp_op_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] P_RESET = 8'h24;

endpackage

// File: rtl/cpu_regfile_if.sv
// cpu_regfile_if: control/write bundle from the decode FSM and register views back to it.
interface cpu_regfile_if
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              stall;
    logic              wr_en;
    logic [2:0]        wr_dest;
    logic [DATA_W-1:0] wr_data;
    logic              auto_nz;
    logic [DATA_W-1:0] flag_we;
    logic [DATA_W-1:0] flag_in;
    pc_op_t            pc_op;
    logic [ADDR_W-1:0] pc_load;
    sp_op_t            sp_op;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic [DATA_W-1:0] sp_reg;
    logic [DATA_W-1:0] status_reg;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] pull_addr;

    modport master (
        output stall, wr_en, wr_dest, wr_data, auto_nz, flag_we, flag_in, pc_op, pc_load, sp_op,
        input  acc_reg, x_reg, y_reg, sp_reg, status_reg, pc, push_addr, pull_addr
    );

    modport slave (
        input  stall, wr_en, wr_dest, wr_data, auto_nz, flag_we, flag_in, pc_op, pc_load, sp_op,
        output acc_reg, x_reg, y_reg, sp_reg, status_reg, pc, push_addr, pull_addr
    );
endinterface

// File: rtl/cpu_regfile_status_flags.sv
// status_flags: P register; full write < auto N/Z < per-bit mask, with bit5=1 and B=0 pinned.
module status_flags
    import cpu_regfile_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              p_wr,
    input  logic              nz_wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] flag_we,
    input  logic [DATA_W-1:0] flag_in,
    output logic [DATA_W-1:0] status_reg
);
    logic [DATA_W-1:0] p_base;
    logic [DATA_W-1:0] p_nz;
    logic [DATA_W-1:0] p_next;

    always_comb begin
        p_base = p_wr ? wr_data : status_reg;
        p_nz = p_base;
        p_nz[FLAG_N] = nz_wr ? wr_data[DATA_W-1] : p_base[FLAG_N];
        p_nz[FLAG_Z] = nz_wr ? ~|wr_data : p_base[FLAG_Z];
        p_next = (p_nz & ~flag_we) | (flag_in & flag_we);
        p_next[FLAG_U] = 1'b1;
        p_next[FLAG_B] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_reg <= DATA_W'(P_RESET);
        else if (!stall) status_reg <= p_next;
    end
endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: 6502 architectural registers A/X/Y/SP/PC with stack addressing; P lives in status_flags.
module cpu_regfile
    import cpu_regfile_pkg::*;
#(
    parameter int                         DATA_W   = 8,
    parameter int                         ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]          PC_RESET = 16'hFFFC,
    parameter logic [DATA_W-1:0]          SP_RESET = 8'hFD,
    parameter logic [ADDR_W-DATA_W-1:0]   SP_PAGE  = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    cpu_regfile_if.slave bus
);
    logic              wr_a, wr_x, wr_y, wr_sp, wr_p;
    logic [DATA_W-1:0] sp_inc;
    logic [DATA_W-1:0] sp_next;
    logic [ADDR_W-1:0] pc_next;

    always_comb begin
        wr_a = bus.wr_en && bus.wr_dest == REG_A;
        wr_x = bus.wr_en && bus.wr_dest == REG_X;
        wr_y = bus.wr_en && bus.wr_dest == REG_Y;
        wr_sp = bus.wr_en && bus.wr_dest == REG_SP;
        wr_p = bus.wr_en && bus.wr_dest == REG_P;
        sp_inc = bus.sp_reg + DATA_W'(1);
        // A direct SP write (TXS) overrides any push/pull in the same cycle
        sp_next = wr_sp ? bus.wr_data :
                  bus.sp_op == SP_PUSH ? bus.sp_reg - DATA_W'(1) :
                  bus.sp_op == SP_PULL ? sp_inc : bus.sp_reg;
        pc_next = bus.pc_op == PC_INC ? bus.pc + ADDR_W'(1) :
                  bus.pc_op == PC_LOAD ? bus.pc_load : bus.pc;
    end

    assign bus.push_addr = {SP_PAGE, bus.sp_reg};
    assign bus.pull_addr = {SP_PAGE, sp_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.acc_reg <= '0;
            bus.x_reg <= '0;
            bus.y_reg <= '0;
            bus.sp_reg <= SP_RESET;
            bus.pc <= PC_RESET;
        end else if (!bus.stall) begin
            if (wr_a) bus.acc_reg <= bus.wr_data;
            if (wr_x) bus.x_reg <= bus.wr_data;
            if (wr_y) bus.y_reg <= bus.wr_data;
            bus.sp_reg <= sp_next;
            bus.pc <= pc_next;
        end
    end

    status_flags #(.DATA_W(DATA_W)) u_flags (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (bus.stall),
        .p_wr      (wr_p),
        .nz_wr     (bus.auto_nz && (wr_a || wr_x || wr_y)),
        .wr_data   (bus.wr_data),
        .flag_we   (bus.flag_we),
        .flag_in   (bus.flag_in),
        .status_reg(bus.status_reg)
    );
endmodule

// File: tb/tb_cpu_regfile.sv
// tb_cpu_regfile: directed vectors against hand-computed register values.
module tb_cpu_regfile;
    import cpu_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;

    cpu_regfile_if #(.DATA_W(8), .ADDR_W(16)) bus ();

    cpu_regfile dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_dest = 3'd0;
        bus.wr_data = 8'h00;
        bus.auto_nz = 1'b0;
        bus.flag_we = 8'h00;
        bus.flag_in = 8'h00;
        bus.pc_op = PC_HOLD;
        bus.pc_load = 16'h0000;
        bus.sp_op = SP_HOLD;
    endtask

    task automatic wr(input logic [2:0] dest, input logic [7:0] data, input logic nz);
        bus.wr_en = 1'b1;
        bus.wr_dest = dest;
        bus.wr_data = data;
        bus.auto_nz = nz;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".a"}, 32'(bus.acc_reg), 32'h00);
        chk({tag, ".x"}, 32'(bus.x_reg), 32'h00);
        chk({tag, ".y"}, 32'(bus.y_reg), 32'h00);
        chk({tag, ".sp"}, 32'(bus.sp_reg), 32'hFD);
        chk({tag, ".pc"}, 32'(bus.pc), 32'hFFFC);
        chk({tag, ".p"}, 32'(bus.status_reg), 32'h24);
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1 chk_reset("rst0");
        chk("rst0.push_addr", 32'(bus.push_addr), 32'h01FD);
        chk("rst0.pull_addr", 32'(bus.pull_addr), 32'h01FE);
        @(posedge clk);
        #1 rst_n = 1'b1;

        wr(REG_A, 8'h80, 1'b1); tick();
        chk("wa.a", 32'(bus.acc_reg), 32'h80);
        chk("wa.p", 32'(bus.status_reg), 32'hA4);

        wr(REG_X, 8'h00, 1'b1); tick();
        chk("wx.x", 32'(bus.x_reg), 32'h00);
        chk("wx.p", 32'(bus.status_reg), 32'h26);
        chk("wx.a", 32'(bus.acc_reg), 32'h80);

        wr(REG_Y, 8'h5A, 1'b0); tick();
        chk("wy.y", 32'(bus.y_reg), 32'h5A);
        chk("wy.p", 32'(bus.status_reg), 32'h26);

        wr(REG_SP, 8'h01, 1'b0); tick();
        chk("sp01", 32'(bus.sp_reg), 32'h01);
        bus.sp_op = SP_PUSH; tick();
        chk("push1", 32'(bus.sp_reg), 32'h00);
        bus.sp_op = SP_PUSH; tick();
        chk("push2", 32'(bus.sp_reg), 32'hFF);
        bus.sp_op = SP_PUSH; tick();
        chk("push3", 32'(bus.sp_reg), 32'hFE);
        chk("push3.push_addr", 32'(bus.push_addr), 32'h01FE);
        chk("push3.pull_addr", 32'(bus.pull_addr), 32'h01FF);

        wr(REG_SP, 8'hFF, 1'b0); bus.sp_op = SP_PULL; tick();
        chk("spwr_wins", 32'(bus.sp_reg), 32'hFF);
        chk("spff.pull_addr", 32'(bus.pull_addr), 32'h0100);
        bus.sp_op = SP_PULL; tick();
        chk("pull_wrap", 32'(bus.sp_reg), 32'h00);
        chk("pull_wrap.push_addr", 32'(bus.push_addr), 32'h0100);
        chk("pull_wrap.pull_addr", 32'(bus.pull_addr), 32'h0101);

        bus.pc_op = PC_LOAD; bus.pc_load = 16'hFFFE; tick();
        chk("pc_fffe", 32'(bus.pc), 32'hFFFE);
        bus.pc_op = PC_INC; tick();
        chk("pc_ffff", 32'(bus.pc), 32'hFFFF);
        bus.pc_op = PC_INC; tick();
        chk("pc_wrap", 32'(bus.pc), 32'h0000);

        bus.stall = 1'b1; bus.pc_op = PC_LOAD; bus.pc_load = 16'h1234;
        wr(REG_A, 8'h11, 1'b1); bus.sp_op = SP_PUSH; bus.flag_we = 8'hFF; bus.flag_in = 8'hFF;
        @(posedge clk); #1;
        chk("stall.pc", 32'(bus.pc), 32'h0000);
        chk("stall.a", 32'(bus.acc_reg), 32'h80);
        chk("stall.sp", 32'(bus.sp_reg), 32'h00);
        chk("stall.p", 32'(bus.status_reg), 32'h26);
        bus.stall = 1'b0; bus.wr_en = 1'b0; bus.sp_op = SP_HOLD; bus.flag_we = 8'h00; tick();
        chk("unstall.pc", 32'(bus.pc), 32'h1234);

        bus.pc_op = pc_op_t'(2'b11); bus.pc_load = 16'hBEEF; tick();
        chk("pc_op11", 32'(bus.pc), 32'h1234);

        wr(REG_P, 8'hFF, 1'b0); bus.flag_we = 8'h01; bus.flag_in = 8'h00; tick();
        chk("p_prec", 32'(bus.status_reg), 32'hEE);

        bus.flag_we = 8'h40; bus.flag_in = 8'h00; tick();
        chk("clr_v", 32'(bus.status_reg), 32'hAE);

        wr(REG_A, 8'h00, 1'b1); bus.flag_we = 8'hC0; bus.flag_in = 8'h40; tick();
        chk("mask.p", 32'(bus.status_reg), 32'h6E);
        chk("mask.a", 32'(bus.acc_reg), 32'h00);

        bus.flag_we = 8'h30; bus.flag_in = 8'h10; tick();
        chk("pinned_b5_b4", 32'(bus.status_reg), 32'h6E);

        wr(3'd5, 8'h33, 1'b1); tick();
        chk("illegal.a", 32'(bus.acc_reg), 32'h00);
        chk("illegal.x", 32'(bus.x_reg), 32'h00);
        chk("illegal.y", 32'(bus.y_reg), 32'h5A);
        chk("illegal.sp", 32'(bus.sp_reg), 32'h00);
        chk("illegal.p", 32'(bus.status_reg), 32'h6E);

        wr(REG_SP, 8'h80, 1'b1); tick();
        chk("sp_nz.sp", 32'(bus.sp_reg), 32'h80);
        chk("sp_nz.p", 32'(bus.status_reg), 32'h6E);

        wr(REG_X, 8'hC3, 1'b1); bus.pc_op = PC_INC; bus.sp_op = SP_PUSH; tick();
        chk("combo.x", 32'(bus.x_reg), 32'hC3);
        chk("combo.pc", 32'(bus.pc), 32'h1235);
        chk("combo.sp", 32'(bus.sp_reg), 32'h7F);
        chk("combo.p", 32'(bus.status_reg), 32'hEC);

        wr(REG_A, 8'h77, 1'b1); bus.pc_op = PC_INC;
        #2 rst_n = 1'b0;
        #1 chk_reset("rst_mid");
        @(posedge clk);
        #1 chk_reset("rst_hold");
        rst_n = 1'b1;
        idle();
        bus.pc_op = PC_INC; tick();
        chk("post_rst.pc", 32'(bus.pc), 32'hFFFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
